// File: rtl/seg_scan_decoder.sv
// Loopback monitor for a multiplexed active-low seven-segment bus: recovers the
// BCD value shown on each digit once its anode/cathode pair has settled.
module seg_scan_decoder #(
  parameter int N_DIGITS      = 8,
  parameter int STABLE_CYCLES = 16,
  parameter int STALE_CYCLES  = 1048576
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_DIGITS-1:0]   an_n,
  input  logic [6:0]            seg_n,
  input  logic                  clear,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic [N_DIGITS-1:0]   digit_err,
  output logic                  frame_done
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int WW = $clog2(STALE_CYCLES + 1);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [N_DIGITS-1:0] ONE = N_DIGITS'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURED} state_t;

  logic [N_DIGITS-1:0] r_an_m, r_an_s, r_an_p;
  logic [6:0]          r_seg_m, r_seg_s, r_seg_p;
  logic [CW-1:0]       r_cnt;
  logic [WW-1:0]       r_wd;
  logic [N_DIGITS-1:0] r_seen;
  logic [N_DIGITS-1:0] r_valid;
  logic [N_DIGITS-1:0] r_err;
  logic [3:0]          r_dig [N_DIGITS];
  logic                r_frame_done;
  state_t              r_state, w_state_next;

  logic [N_DIGITS-1:0] w_an_lo;
  logic                w_onehot;
  logic                w_same;
  logic                w_settled;
  logic                w_capture;
  logic [IW-1:0]       w_idx;
  logic [3:0]          w_val;
  logic                w_bad;
  logic [N_DIGITS-1:0] w_cap_mask;
  logic [N_DIGITS-1:0] w_seen_next;
  logic                w_frame;
  logic                w_stale;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_m  <= '1;
      r_an_s  <= '1;
      r_an_p  <= '1;
      r_seg_m <= '1;
      r_seg_s <= '1;
      r_seg_p <= '1;
    end else begin
      r_an_m  <= an_n;
      r_an_s  <= r_an_m;
      r_an_p  <= r_an_s;
      r_seg_m <= seg_n;
      r_seg_s <= r_seg_m;
      r_seg_p <= r_seg_s;
    end
  end

  assign w_an_lo  = ~r_an_s;
  assign w_onehot = (w_an_lo != '0) && ((w_an_lo & (w_an_lo - ONE)) == '0);
  assign w_same   = (r_an_s == r_an_p) && (r_seg_s == r_seg_p);

  // Any segment or anode movement restarts the count, so ghosting never captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!w_same || !w_onehot) begin
      r_cnt <= '0;
    end else if (r_cnt != CW'(STABLE_CYCLES)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_settled = w_onehot && w_same && (r_cnt == CW'(STABLE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_onehot) w_state_next = S_SETTLE;
        end
        S_SETTLE: begin
          if (!w_onehot)     w_state_next = S_IDLE;
          else if (w_settled) w_state_next = S_CAPTURED;
        end
        S_CAPTURED: begin
          if (!w_onehot)   w_state_next = S_IDLE;
          else if (!w_same) w_state_next = S_SETTLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_capture = (r_state == S_SETTLE) && w_settled && !clear;
  end

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!r_an_s[i]) w_idx = IW'(i);
    end
  end

  always_comb begin
    w_bad = 1'b0;
    case (r_seg_s)
      7'b1000000: w_val = 4'd0;
      7'b1111001: w_val = 4'd1;
      7'b0100100: w_val = 4'd2;
      7'b0110000: w_val = 4'd3;
      7'b0011001: w_val = 4'd4;
      7'b0010010: w_val = 4'd5;
      7'b0000010: w_val = 4'd6;
      7'b1111000: w_val = 4'd7;
      7'b0000000: w_val = 4'd8;
      7'b0010000: w_val = 4'd9;
      7'b1111111: w_val = 4'hF;
      default: begin
        w_val = 4'hF;
        w_bad = 1'b1;
      end
    endcase
  end

  assign w_cap_mask  = w_capture ? (ONE << w_idx) : '0;
  assign w_seen_next = r_seen | w_cap_mask;
  assign w_frame     = !clear && (&w_seen_next);
  assign w_stale     = !clear && !w_frame && (r_wd == WW'(STALE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame;
      if (clear || w_frame || w_stale) begin
        r_wd <= '0;
      end else if (r_wd != WW'(STALE_CYCLES)) begin
        r_wd <= r_wd + WW'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dig[gi]   <= 4'hF;
          r_valid[gi] <= 1'b0;
          r_err[gi]   <= 1'b0;
          r_seen[gi]  <= 1'b0;
        end else if (clear) begin
          r_dig[gi]   <= 4'hF;
          r_valid[gi] <= 1'b0;
          r_err[gi]   <= 1'b0;
          r_seen[gi]  <= 1'b0;
        end else begin
          if (w_cap_mask[gi]) begin
            r_dig[gi] <= w_val;
            if (w_bad) r_err[gi] <= 1'b1;
          end
          r_valid[gi] <= w_cap_mask[gi] | (r_valid[gi] & ~w_stale);
          r_seen[gi]  <= (w_frame || w_stale) ? 1'b0 : w_seen_next[gi];
        end
      end
      assign digits[4*gi +: 4] = r_dig[gi];
    end
  endgenerate

  assign digit_valid = r_valid;
  assign digit_err   = r_err;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: single dwell, full scans, ghosting,
// bad patterns, invalid anodes, stale timeout and asynchronous reset.
module tb_seg_scan_decoder;

  localparam int N  = 8;
  localparam int SC = 16;
  localparam int ST = 400;  // long enough for one full 8x32 scan to finish

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [N-1:0]  an_n = '1;
  logic [6:0]    seg_n = '1;
  logic [4*N-1:0] digits;
  logic [N-1:0]  digit_valid;
  logic [N-1:0]  digit_err;
  logic          frame_done;

  int errors = 0;
  int checks = 0;
  int fd_count = 0;

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000};

  seg_scan_decoder #(
    .N_DIGITS(N),
    .STABLE_CYCLES(SC),
    .STALE_CYCLES(ST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .an_n(an_n),
    .seg_n(seg_n),
    .clear(clear),
    .digits(digits),
    .digit_valid(digit_valid),
    .digit_err(digit_err),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (frame_done === 1'b1) fd_count++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    cyc(3);
    chk("rst_digits", digits, 32'hFFFFFFFF);
    chk("rst_valid", {24'h0, digit_valid}, 32'h0);
    chk("rst_err", {24'h0, digit_err}, 32'h0);
    chk("rst_frame", {31'h0, frame_done}, 32'h0);
    rst_n = 1'b1;
    cyc(1);

    // Single dwell on digit 0 showing 2
    an_n = 8'hFE; seg_n = pat[2];
    cyc(10);
    chk("t1_early_valid", {24'h0, digit_valid}, 32'h0);
    cyc(10);
    chk("t1_digits", digits, 32'hFFFFFFF2);
    chk("t1_valid", {24'h0, digit_valid}, 32'h01);
    chk("t1_err", {24'h0, digit_err}, 32'h0);
    cyc(40);
    chk("t1_hold_digits", digits, 32'hFFFFFFF2);
    chk("t1_hold_valid", {24'h0, digit_valid}, 32'h01);

    // Two full scans of 0..7, one frame_done per scan
    pulse_clear();
    for (int s = 0; s < 2; s++) begin
      fd_count = 0;
      for (int d = 0; d < 8; d++) begin
        an_n = ~(8'h01 << d);
        seg_n = pat[d];
        cyc(32);
      end
      chk($sformatf("t2_frames_%0d", s), fd_count, 32'd1);
      chk($sformatf("t2_digits_%0d", s), digits, 32'h76543210);
      chk($sformatf("t2_valid_%0d", s), {24'h0, digit_valid}, 32'hFF);
    end

    // Ghosting on digit 3: toggling every 5 cycles never settles
    pulse_clear();
    an_n = 8'hF7;
    for (int i = 0; i < 12; i++) begin
      seg_n = (i % 2 == 1) ? pat[6] : pat[1];
      cyc(5);
    end
    chk("t3_valid", {24'h0, digit_valid}, 32'h0);
    chk("t3_digits", digits, 32'hFFFFFFFF);

    // Undecodable pattern on digit 5, sticky error, cleared by clear
    pulse_clear();
    an_n = 8'hDF; seg_n = 7'b0101010;
    cyc(40);
    chk("t4_bad_digits", digits, 32'hFFFFFFFF);
    chk("t4_bad_err", {24'h0, digit_err}, 32'h20);
    chk("t4_bad_valid", {24'h0, digit_valid}, 32'h20);
    seg_n = pat[9];
    cyc(40);
    chk("t4_nine_digits", digits, 32'hFF9FFFFF);
    chk("t4_sticky_err", {24'h0, digit_err}, 32'h20);
    pulse_clear();
    chk("t4_clr_err", {24'h0, digit_err}, 32'h0);
    chk("t4_clr_valid", {24'h0, digit_valid}, 32'h0);
    chk("t4_clr_digits", digits, 32'hFFFFFFFF);

    // Two anodes low: ignored; then idle bus times out valid bits
    an_n = 8'hFD; seg_n = pat[7];
    cyc(40);
    chk("t5_cap_digits", digits, 32'hFFFFFF7F);
    chk("t5_cap_valid", {24'h0, digit_valid}, 32'h02);
    an_n = 8'hF3; seg_n = pat[4];
    cyc(100);
    chk("t5_multi_valid", {24'h0, digit_valid}, 32'h02);
    chk("t5_multi_digits", digits, 32'hFFFFFF7F);
    an_n = 8'hFF; seg_n = 7'h7F;
    cyc(ST);
    chk("t5_stale_valid", {24'h0, digit_valid}, 32'h0);
    chk("t5_stale_digits", digits, 32'hFFFFFF7F);

    // Asynchronous reset during SETTLE
    an_n = 8'hFE; seg_n = pat[3];
    cyc(10);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_digits", digits, 32'hFFFFFFFF);
    chk("t6_rst_valid", {24'h0, digit_valid}, 32'h0);
    chk("t6_rst_frame", {31'h0, frame_done}, 32'h0);
    cyc(3);
    rst_n = 1'b1;
    cyc(15);
    chk("t6_early_valid", {24'h0, digit_valid}, 32'h0);
    cyc(10);
    chk("t6_digits", digits, 32'hFFFFFFF3);
    chk("t6_valid", {24'h0, digit_valid}, 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
